// File: rtl/mul8_seq_ctrl_pkg.sv
// Shared types and constants for the 8x8 sequential multiplier built around one 4x4 nibble multiplier.
package mul8_seq_ctrl_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned PP_W   = 2 * NIB_W;
    localparam int unsigned PROD_W = 2 * OP_W;
    localparam int unsigned STEPS  = 4;
    localparam int unsigned STEP_W = 2;

    // Left shift applied to each step's nibble partial product
    localparam int unsigned STEP_SHIFT [STEPS] = '{0, 4, 4, 8};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } operands_t;

    function automatic logic [PROD_W-1:0] place_pp(input logic [PP_W-1:0] pp,
                                                   input logic [STEP_W-1:0] step);
        return PROD_W'(pp) << STEP_SHIFT[step];
    endfunction

endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// Operand/result valid-ready bus between the operand capture logic and the multiplier sequencer.
interface mul8_seq_ctrl_if;
    import mul8_seq_ctrl_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] product;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, product);

    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, product);
endinterface

// File: rtl/mul8_seq_ctrl_nibble_mul4.sv
// Combinational 4x4 unsigned array multiplier: AND partial products summed by rows of full adders.
module nibble_mul4
    import mul8_seq_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    output logic [PP_W-1:0]  p
);

    function automatic logic [1:0] full_add(input logic s, input logic t, input logic ci);
        return {(s & t) | (s & ci) | (t & ci), s ^ t ^ ci};
    endfunction

    logic [PP_W-1:0] sum;
    logic            carry;

    // Row r adds x&y[r] at weight r; the running sum never reaches bit r+4, so the carry lands there
    always_comb begin
        sum   = {4'b0000, x & {NIB_W{y[0]}}};
        carry = 1'b0;
        for (int r = 1; r < int'(NIB_W); r++) begin
            carry = 1'b0;
            for (int j = 0; j < int'(NIB_W); j++) begin
                {carry, sum[r+j]} = full_add(sum[r+j], x[j] & y[r], carry);
            end
            sum[r+NIB_W] = carry;
        end
    end

    assign p = sum;

endmodule

// File: rtl/mul8_seq_ctrl.sv
// 8x8 -> 16 unsigned multiplier sequencing one shared 4x4 nibble multiplier over four steps.
module mul8_seq_ctrl
    import mul8_seq_ctrl_pkg::*;
#(
    parameter bit          ALLOW_B2B = 1'b1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    mul8_seq_ctrl_if.slave   bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    operands_t         ops_q, ops_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [PROD_W-1:0] product_q, product_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic              in_ready_c;
    logic              accept_c;
    logic              handshake_c;
    logic [NIB_W-1:0]  nib_a_c;
    logic [NIB_W-1:0]  nib_b_c;
    logic [PP_W-1:0]   pp_c;

    // Ready in IDLE, or in DONE while the result is being taken when back-to-back is enabled
    assign in_ready_c  = ~rst & ((state_q == IDLE) |
                         (ALLOW_B2B & (state_q == DONE) & out_valid_q & bus.out_ready));
    assign accept_c    = bus.in_valid & in_ready_c & ~flush;
    assign handshake_c = out_valid_q & bus.out_ready & ~flush;

    // step[0] picks the high nibble of a, step[1] the high nibble of b
    assign nib_a_c = step_q[0] ? ops_q.a[7:4] : ops_q.a[3:0];
    assign nib_b_c = step_q[1] ? ops_q.b[7:4] : ops_q.b[3:0];

    nibble_mul4 u_nibble_mul4 (
        .x (nib_a_c),
        .y (nib_b_c),
        .p (pp_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            ops_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            ops_q       <= ops_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
            busy_q      <= busy_d;
            op_count_q  <= op_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        ops_d       = ops_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        product_d   = product_q;
        op_count_d  = op_count_q;

        if (flush) begin
            state_d     = IDLE;
            step_d      = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        ops_d   = '{a: bus.a, b: bus.b};
                        acc_d   = '0;
                        step_d  = '0;
                        state_d = MUL;
                    end
                end
                MUL: begin
                    acc_d  = acc_q + place_pp(pp_c, step_q);
                    step_d = step_q + STEP_W'(1);
                    if (step_q == STEP_W'(STEPS - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle loads the result register; it then holds until taken
                    if (!out_valid_q) begin
                        out_valid_d = 1'b1;
                        product_d   = acc_q;
                    end else if (handshake_c) begin
                        out_valid_d = 1'b0;
                        if (op_count_q != '1) begin
                            op_count_d = op_count_q + CNT_W'(1);
                        end
                        if (accept_c) begin
                            ops_d   = '{a: bus.a, b: bus.b};
                            acc_d   = '0;
                            step_d  = '0;
                            state_d = MUL;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign busy          = busy_q;
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Bench for mul8_seq_ctrl: dut0 back-to-back with 8-bit count, dut1 no back-to-back with 2-bit count.
module tb_mul8_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] flush;
    logic [1:0] in_valid;
    logic [1:0] out_ready;
    logic [7:0] a_s [2];
    logic [7:0] b_s [2];

    logic [1:0]  in_ready_s;
    logic [1:0]  out_valid_s;
    logic [1:0]  busy_s;
    logic [15:0] product_s [2];
    logic [7:0]  opc_s [2];
    logic [7:0]  opc0;
    logic [1:0]  opc1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul8_seq_ctrl_if bus0 ();
    mul8_seq_ctrl_if bus1 ();

    assign bus0.in_valid  = in_valid[0];
    assign bus0.a         = a_s[0];
    assign bus0.b         = b_s[0];
    assign bus0.out_ready = out_ready[0];
    assign bus1.in_valid  = in_valid[1];
    assign bus1.a         = a_s[1];
    assign bus1.b         = b_s[1];
    assign bus1.out_ready = out_ready[1];

    assign in_ready_s   = {bus1.in_ready, bus0.in_ready};
    assign out_valid_s  = {bus1.out_valid, bus0.out_valid};
    assign product_s[0] = bus0.product;
    assign product_s[1] = bus1.product;
    assign opc_s[0]     = opc0;
    assign opc_s[1]     = {6'b000000, opc1};

    mul8_seq_ctrl #(.ALLOW_B2B(1'b1), .CNT_W(8)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush[0]),
        .bus      (bus0.slave),
        .busy     (busy_s[0]),
        .op_count (opc0)
    );

    mul8_seq_ctrl #(.ALLOW_B2B(1'b0), .CNT_W(2)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush[1]),
        .bus      (bus1.slave),
        .busy     (busy_s[1]),
        .op_count (opc1)
    );

    task automatic chk(input string nm, input int i, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, got, exp, $time);
        end
    endtask

    // Transaction-level model: a result appears 5 edges after acceptance and is held until taken
    bit          m_busy [2];
    bit          m_ov   [2];
    int          m_timer[2];
    int          m_opc  [2];
    logic [15:0] m_prod [2];
    logic [15:0] m_next [2];

    function automatic bit exp_in_ready(input int i);
        return !rst && (!m_busy[i] || ((i == 0) && m_ov[i] && out_ready[i]));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i]  <= 1'b0;
                m_ov[i]    <= 1'b0;
                m_timer[i] <= 0;
                m_opc[i]   <= 0;
                m_prod[i]  <= 16'h0000;
                m_next[i]  <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit          acc_f, hs, nb, nov;
                int          nt, no;
                logic [15:0] np;
                acc_f = in_valid[i] && exp_in_ready(i) && !flush[i];
                hs    = m_ov[i] && out_ready[i] && !flush[i];
                nb    = m_busy[i];
                nov   = m_ov[i];
                nt    = m_timer[i];
                no    = m_opc[i];
                np    = m_prod[i];
                if (flush[i]) begin
                    nb  = 1'b0;
                    nov = 1'b0;
                    nt  = 0;
                end else begin
                    if (hs) begin
                        nov = 1'b0;
                        nb  = 1'b0;
                        if (no < ((i == 0) ? 255 : 3)) no++;
                    end
                    if (nb && !nov) begin
                        nt++;
                        if (nt == 5) begin
                            nov = 1'b1;
                            np  = m_next[i];
                        end
                    end
                    if (acc_f) begin
                        nb = 1'b1;
                        nt = 0;
                        m_next[i] <= 16'(a_s[i]) * 16'(b_s[i]);
                    end
                end
                m_busy[i]  <= nb;
                m_ov[i]    <= nov;
                m_timer[i] <= nt;
                m_opc[i]   <= no;
                m_prod[i]  <= np;
            end
        end
    end

    // Every cycle, once inputs have settled, compare both DUTs against the model
    always @(negedge clk) begin
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("in_ready", i, 16'(in_ready_s[i]), 16'(exp_in_ready(i)));
            chk("out_valid", i, 16'(out_valid_s[i]), 16'(m_ov[i]));
            chk("busy", i, 16'(busy_s[i]), 16'(m_busy[i]));
            chk("op_count", i, 16'(opc_s[i]), 16'(m_opc[i]));
            if (m_ov[i]) chk("product", i, product_s[i], m_prod[i]);
        end
    end

    task automatic accept(input int i, input logic [7:0] av, input logic [7:0] bv);
        int w;
        @(negedge clk);
        a_s[i] = av;
        b_s[i] = bv;
        in_valid[i] = 1'b1;
        w = 0;
        #1;
        while (!in_ready_s[i] && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 20) chk("accept_timeout", i, 16'(in_ready_s[i]), 16'h1);
        @(posedge clk);
        @(negedge clk);
        in_valid[i] = 1'b0;
    endtask

    // Called at the negedge after the acceptance edge; returns with out_valid high
    task automatic wait_valid(input int i, input logic [15:0] lit);
        int lat;
        lat = 0;
        while (lat < 20) begin
            #1;
            if (out_valid_s[i]) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", i, 16'(lat), 16'd5);
        chk("product_lit", i, product_s[i], lit);
    endtask

    task automatic take(input int i, input int exp_opc);
        out_ready[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[i] = 1'b0;
        #1;
        chk("opc_lit", i, 16'(opc_s[i]), 16'(exp_opc));
    endtask

    task automatic do_op(input int i, input logic [7:0] av, input logic [7:0] bv,
                         input int stall, input logic [15:0] lit, input int exp_opc);
        int opc_before;
        accept(i, av, bv);
        wait_valid(i, lit);
        opc_before = int'(opc_s[i]);
        repeat (stall) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("stall_valid", i, 16'(out_valid_s[i]), 16'h1);
            chk("stall_product", i, product_s[i], lit);
            chk("stall_in_ready", i, 16'(in_ready_s[i]), 16'h0);
            chk("stall_opc", i, 16'(opc_s[i]), 16'(opc_before));
        end
        take(i, exp_opc);
    endtask

    task automatic b2b(input int i, input int exp_opc);
        accept(i, 8'h12, 8'h34);
        wait_valid(i, 16'h03A8);
        out_ready[i] = 1'b1;
        in_valid[i]  = 1'b1;
        a_s[i] = 8'h80;
        b_s[i] = 8'h02;
        #1;
        chk("b2b_in_ready", i, 16'(in_ready_s[i]), (i == 0) ? 16'h1 : 16'h0);
        @(posedge clk);
        @(negedge clk);
        out_ready[i] = 1'b0;
        if (i == 0) begin
            in_valid[i] = 1'b0;
            #1;
            chk("b2b_busy", i, 16'(busy_s[i]), 16'h1);
        end else begin
            #1;
            chk("idle_in_ready", i, 16'(in_ready_s[i]), 16'h1);
            chk("idle_busy", i, 16'(busy_s[i]), 16'h0);
            @(posedge clk);
            @(negedge clk);
            in_valid[i] = 1'b0;
        end
        wait_valid(i, 16'h0100);
        take(i, exp_opc);
    endtask

    task automatic chk_reset_vals(input int i);
        chk("rst_in_ready", i, 16'(in_ready_s[i]), 16'h0);
        chk("rst_out_valid", i, 16'(out_valid_s[i]), 16'h0);
        chk("rst_busy", i, 16'(busy_s[i]), 16'h0);
        chk("rst_product", i, product_s[i], 16'h0000);
        chk("rst_opc", i, 16'(opc_s[i]), 16'h0);
    endtask

    initial begin
        rst = 1'b0;
        flush = 2'b00;
        in_valid = 2'b00;
        out_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            a_s[i] = 8'h00;
            b_s[i] = 8'h00;
        end
        #1 rst = 1'b1;
        #1;
        chk_reset_vals(0);
        chk_reset_vals(1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_idle_ready", 0, 16'(in_ready_s[0]), 16'h1);
        chk("first_idle_ready", 1, 16'(in_ready_s[1]), 16'h1);

        // dut1: 2-bit counter saturates at 3
        do_op(1, 8'h0F, 8'h0F, 0, 16'h00E1, 1);
        do_op(1, 8'hFF, 8'hFF, 0, 16'hFE01, 2);
        do_op(1, 8'hA5, 8'h3C, 0, 16'h26AC, 3);
        do_op(1, 8'h00, 8'h7B, 0, 16'h0000, 3);
        do_op(1, 8'h12, 8'h34, 3, 16'h03A8, 3);

        do_op(0, 8'h0F, 8'h0F, 0, 16'h00E1, 1);
        do_op(0, 8'hFF, 8'hFF, 0, 16'hFE01, 2);
        do_op(0, 8'hA5, 8'h3C, 0, 16'h26AC, 3);
        do_op(0, 8'h00, 8'h7B, 0, 16'h0000, 4);
        do_op(0, 8'h12, 8'h34, 3, 16'h03A8, 5);

        b2b(0, 7);
        b2b(1, 3);

        // Reset during step 2 of 0xA5*0x3C
        accept(0, 8'hA5, 8'h3C);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals(0);
        chk_reset_vals(1);
        @(negedge clk);
        rst = 1'b0;
        do_op(0, 8'h03, 8'h05, 0, 16'h000F, 1);

        // Flush during step 1
        accept(0, 8'hA5, 8'h3C);
        @(posedge clk);
        @(negedge clk);
        flush[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush[0] = 1'b0;
        #1;
        chk("flush_busy", 0, 16'(busy_s[0]), 16'h0);
        chk("flush_in_ready", 0, 16'(in_ready_s[0]), 16'h1);
        chk("flush_opc", 0, 16'(opc_s[0]), 16'h1);
        repeat (7) begin
            @(negedge clk);
            #1;
            chk("flush_no_valid", 0, 16'(out_valid_s[0]), 16'h0);
        end
        do_op(0, 8'h03, 8'h05, 0, 16'h000F, 2);

        repeat (3) @(negedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
